// File: rtl/apb_reg_slave.sv
// APB4 completer exposing a bank of memory-mapped registers, with configurable
// wait states, byte strobes, read-only status slots and PSLVERR reporting.
module apb_reg_slave #(
   parameter int                         ADDR_W      = 32,
   parameter int                         DATA_W      = 32,
   parameter int                         NUM_REGS    = 8,
   parameter int                         WAIT_STATES = 0,
   parameter logic [NUM_REGS-1:0]        RO_MASK     = '0,
   parameter logic [NUM_REGS*DATA_W-1:0] RST_VAL     = '0
) (
   input  logic                         pclk,
   input  logic                         presetn,
   input  logic [ADDR_W-1:0]            paddr,
   input  logic                         psel,
   input  logic                         penable,
   input  logic                         pwrite,
   input  logic [DATA_W-1:0]            pwdata,
   input  logic [DATA_W/8-1:0]          pstrb,
   output logic [DATA_W-1:0]            prdata,
   output logic                         pready,
   output logic                         pslverr,
   output logic [NUM_REGS*DATA_W-1:0]   reg_q,
   output logic [NUM_REGS-1:0]          wr_pulse,
   input  logic [NUM_REGS*DATA_W-1:0]   status_in
);

   localparam int STRB_W = DATA_W / 8;
   localparam int OFS    = $clog2(STRB_W);
   localparam int IDX_W  = ADDR_W - OFS;

   localparam logic [0:0] IDLE   = 1'b0;
   localparam logic [0:0] ACCESS = 1'b1;

   logic [0:0]        state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic              write_q, write_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [STRB_W-1:0] strb_q, strb_d;
   logic              err_q, err_d;
   logic              pready_q, pready_d;
   logic              pslverr_q, pslverr_d;
   logic [DATA_W-1:0] prdata_q, prdata_d;
   logic [NUM_REGS-1:0] wr_pulse_q, wr_pulse_d;
   logic [DATA_W-1:0] regs_q [NUM_REGS];
   logic [DATA_W-1:0] regs_d [NUM_REGS];

   logic [IDX_W-1:0]  pidx;
   logic              in_range, ro_hit, setup_err, commit;
   logic [DATA_W-1:0] rd_val;

   assign pidx   = paddr[ADDR_W-1:OFS];
   assign commit = (state_q == ACCESS) && psel && penable && pready_q;

   // Decode of the address presented in the setup phase.
   always_comb begin
      in_range = 1'b0;
      ro_hit   = 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (pidx == IDX_W'(i)) begin
            in_range = 1'b1;
            ro_hit   = RO_MASK[i];
         end
      end
      setup_err = (|paddr[OFS-1:0]) || !in_range || (pwrite && ro_hit);
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      idx_d      = idx_q;
      write_d    = write_q;
      wdata_d    = wdata_q;
      strb_d     = strb_q;
      err_d      = err_q;
      wr_pulse_d = '0;
      for (int i = 0; i < NUM_REGS; i++) regs_d[i] = regs_q[i];

      case (state_q)
         IDLE: begin
            if (psel && !penable) begin
               state_d = ACCESS;
               cnt_d   = 4'(WAIT_STATES);
               idx_d   = pidx;
               write_d = pwrite;
               wdata_d = pwdata;
               strb_d  = pstrb;
               err_d   = setup_err;
            end
         end
         default: begin
            if (!psel) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (commit) begin
               state_d = IDLE;
               cnt_d   = '0;
               if (write_q && !err_q) begin
                  for (int i = 0; i < NUM_REGS; i++) begin
                     if (idx_q == IDX_W'(i)) begin
                        wr_pulse_d[i] = 1'b1;
                        for (int b = 0; b < STRB_W; b++)
                           if (strb_q[b]) regs_d[i][8*b +: 8] = wdata_q[8*b +: 8];
                     end
                  end
               end
            end else if (cnt_q != '0) begin
               cnt_d = cnt_q - 4'd1;
            end
         end
      endcase
   end

   // Read source for the transfer about to reach its ready cycle.
   always_comb begin
      rd_val = '0;
      for (int i = 0; i < NUM_REGS; i++)
         if (idx_d == IDX_W'(i))
            rd_val = RO_MASK[i] ? status_in[i*DATA_W +: DATA_W] : regs_q[i];
   end

   always_comb begin
      pready_d  = (state_d == ACCESS) && (cnt_d == '0);
      pslverr_d = 1'b0;
      prdata_d  = '0;
      if (pready_d && !pready_q) begin
         pslverr_d = err_d;
         prdata_d  = (write_d || err_d) ? '0 : rd_val;
      end else if (pready_d) begin
         pslverr_d = pslverr_q;
         prdata_d  = prdata_q;
      end
   end

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         idx_q      <= '0;
         write_q    <= 1'b0;
         wdata_q    <= '0;
         strb_q     <= '0;
         err_q      <= 1'b0;
         pready_q   <= 1'b0;
         pslverr_q  <= 1'b0;
         prdata_q   <= '0;
         wr_pulse_q <= '0;
         for (int i = 0; i < NUM_REGS; i++)
            regs_q[i] <= RO_MASK[i] ? '0 : RST_VAL[i*DATA_W +: DATA_W];
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         write_q    <= write_d;
         wdata_q    <= wdata_d;
         strb_q     <= strb_d;
         err_q      <= err_d;
         pready_q   <= pready_d;
         pslverr_q  <= pslverr_d;
         prdata_q   <= prdata_d;
         wr_pulse_q <= wr_pulse_d;
         for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
      end
   end

   // RO slots are never written and reset to zero, so they read back as 0 here.
   always_comb begin
      for (int i = 0; i < NUM_REGS; i++) reg_q[i*DATA_W +: DATA_W] = regs_q[i];
   end

   assign pready   = pready_q;
   assign pslverr  = pslverr_q;
   assign prdata   = prdata_q;
   assign wr_pulse = wr_pulse_q;

endmodule
